// File: rtl/pillar_pkg.sv
// Shared geometry and state encoding for the rising-pillar trigger path.
// Animator and background lookup import the same constants.
package pillar_pkg;

  localparam int PILLAR_X0       = 116;
  localparam int PILLAR_W        = 20;
  localparam int STAND_Y         = 143;
  localparam int RISE_STEPS      = 25;
  localparam int RISE_PX         = 3;
  localparam int TIMEOUT_FRAMES  = 63;
  localparam int DEBOUNCE_FRAMES = 2;

  localparam int FCNT_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam int DBC_W  = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    COMMIT = 3'd2,
    RAISED = 3'd3,
    FAULT  = 3'd4
  } state_e;

  function automatic logic [7:0] y_raised();
    int d;
    d = STAND_Y - RISE_STEPS * RISE_PX;
    return (d < 0) ? 8'd0 : 8'(d);
  endfunction

  localparam logic [7:0] Y_COMMIT = y_raised();

endpackage

// File: rtl/key_edge_detect.sv
// Lever synchroniser and press pulse; PILLAR_DEBOUNCE_EN adds
// frame-rate debounce with re-arm on release.
module key_edge_detect
  import pillar_pkg::*;
(
  input  logic clock,
  input  logic resetn,
  input  logic frame_tick,
  input  logic lever_n,
  output logic press_pulse
);

  logic s1_q, s2_q;
  logic pulse_q, pulse_d;

  // Sync flops reset to the idle (released) level
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= lever_n;
      s2_q    <= s1_q;
      pulse_q <= pulse_d;
    end
  end

`ifdef PILLAR_DEBOUNCE_EN
  logic [DBC_W-1:0] low_q, low_d;
  logic             arm_q, arm_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      low_q <= '0;
      arm_q <= 1'b1;
    end else begin
      low_q <= low_d;
      arm_q <= arm_d;
    end
  end

  always_comb begin
    pulse_d = 1'b0;
    low_d   = low_q;
    arm_d   = arm_q;
    if (frame_tick) begin
      if (s2_q) begin
        low_d = '0;
        arm_d = 1'b1;
      end else begin
        if (low_q != DBC_W'(DEBOUNCE_FRAMES))
          low_d = low_q + 1'b1;
        if (arm_q &&
            low_q == DBC_W'(DEBOUNCE_FRAMES - 1)) begin
          pulse_d = 1'b1;
          arm_d   = 1'b0;
        end
      end
    end
  end
`else
  logic s3_q;
  logic unused_tick;

  assign unused_tick = frame_tick;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) s3_q <= 1'b1;
    else         s3_q <= s2_q;
  end

  always_comb begin
    pulse_d = s3_q & ~s2_q;
  end
`endif

  assign press_pulse = pulse_q;

endmodule

// File: rtl/pillar_trigger_ctrl.sv
// Pillar trigger FSM: start/hold animator, commit Y, lock pillar.
// Optional PILLAR_DEBOUNCE_EN debounces the lever in key_edge_detect.
module pillar_trigger_ctrl
  import pillar_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [8:0] char_X,
  input  logic [7:0] char_Y,
  input  logic       lever_n,
  input  logic       doneAnimation,
  output logic       start_pillar,
  output logic       move_lock,
  output logic [7:0] char_Y_out,
  output logic       pillar_raised,
  output logic       fault
);

  localparam logic [8:0] X_LO = 9'(PILLAR_X0);
  localparam logic [8:0] X_HI = 9'(PILLAR_X0 + PILLAR_W);
  localparam logic [7:0] Y_ON = 8'(STAND_Y);
  localparam logic [FCNT_W-1:0] TMO = FCNT_W'(TIMEOUT_FRAMES);

  logic press_pulse;
  logic in_win, on_pillar;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              age_q, age_d;
  logic [7:0]        ycmt_q, ycmt_d;

  key_edge_detect u_key (
    .clock       (clock),
    .resetn      (resetn),
    .frame_tick  (frame_tick),
    .lever_n     (lever_n),
    .press_pulse (press_pulse)
  );

  assign in_win    = (char_X >= X_LO) && (char_X < X_HI);
  assign on_pillar = in_win && (char_Y == Y_ON);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      age_q   <= 1'b0;
      ycmt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      age_q   <= age_d;
      ycmt_q  <= ycmt_d;
    end
  end

  // age_q gates a stale done until start has been high two cycles
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    age_d   = age_q;
    ycmt_d  = ycmt_q;
    unique case (state_q)
      IDLE: begin
        fcnt_d = '0;
        age_d  = 1'b0;
        if (press_pulse && on_pillar)
          state_d = RUN;
      end
      RUN: begin
        age_d = 1'b1;
        if (frame_tick && fcnt_q != TMO)
          fcnt_d = fcnt_q + 1'b1;
        if (doneAnimation && age_q)
          state_d = COMMIT;
        else if (fcnt_q == TMO)
          state_d = FAULT;
      end
      COMMIT: begin
        ycmt_d  = Y_COMMIT;
        state_d = RAISED;
      end
      RAISED: ;
      FAULT:  ;
      default: state_d = IDLE;
    endcase
  end

  assign start_pillar  = (state_q == RUN) ||
                         (state_q == COMMIT) ||
                         (state_q == RAISED);
  assign move_lock     = (state_q == RUN) ||
                         (state_q == COMMIT);
  assign pillar_raised = (state_q == RAISED);
  assign fault         = (state_q == FAULT);
  assign char_Y_out    = (pillar_raised && in_win) ?
                         ycmt_q : char_Y;

endmodule
